// File: rtl/pipeline_ctrl_if.sv
// Stage-control bus between the pipeline sequencer and the datapath.
// Carries hazard/debug inputs, per-stage rst/en pairs and event counters.
//
// Signals:
//   reg_stall, is_branch_mem : hazard inputs from ID / MEM
//   debug_en, debug_step     : debug halt and step request
//   <stage>_rst, <stage>_en  : IF, ID, EXE, MEM, WB control
//   halted                   : sequencer is in HALT
//   stall_cnt, flush_cnt     : saturating event counters
// master drives the stage controls; slave drives hazard/debug inputs.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             reg_stall;
  logic             is_branch_mem;
  logic             debug_en;
  logic             debug_step;
  logic             if_rst;
  logic             if_en;
  logic             id_rst;
  logic             id_en;
  logic             exe_rst;
  logic             exe_en;
  logic             mem_rst;
  logic             mem_en;
  logic             wb_rst;
  logic             wb_en;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  reg_stall,
    input  is_branch_mem,
    input  debug_en,
    input  debug_step,
    output if_rst,
    output if_en,
    output id_rst,
    output id_en,
    output exe_rst,
    output exe_en,
    output mem_rst,
    output mem_en,
    output wb_rst,
    output wb_en,
    output halted,
    output stall_cnt,
    output flush_cnt
  );

  modport slave (
    output reg_stall,
    output is_branch_mem,
    output debug_en,
    output debug_step,
    input  if_rst,
    input  if_en,
    input  id_rst,
    input  id_en,
    input  exe_rst,
    input  exe_en,
    input  mem_rst,
    input  mem_en,
    input  wb_rst,
    input  wb_en,
    input  halted,
    input  stall_cnt,
    input  flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stage-control sequencer for the 5-stage MIPS pipeline.
// Handles reset hold, load-use stalls, MEM-resolved branch flushes,
// debug halt/single-step and saturating stall/flush counters.
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : pipeline_ctrl_if.master (hazards in, stage controls out)
module pipeline_ctrl #(
  parameter int RST_HOLD = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipeline_ctrl_if.master   bus
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    STEP = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_INIT = 4'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       hold;
  logic             step_d;
  logic             step_edge;
  logic             active;
  logic             do_flush;
  logic             do_stall;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic if_rst, if_en;
  logic id_rst, id_en;
  logic exe_rst, exe_en;
  logic mem_rst, mem_en;
  logic wb_rst, wb_en;
  logic halted;

  assign step_edge = bus.debug_step & ~step_d;
  assign active    = ~rst & ((state == RUN) | (state == STEP));

  // Branch outranks stall: a stalled instruction in ID is younger
  // than the branch and gets flushed anyway.
  assign do_flush = active & bus.is_branch_mem;
  assign do_stall = active & bus.reg_stall & ~bus.is_branch_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INIT;
      hold   <= HOLD_INIT;
      step_d <= 1'b0;
    end else begin
      state  <= state_nxt;
      step_d <= bus.debug_step;
      if (state == INIT && hold != 4'd0)
        hold <= hold - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT: begin
        if (hold == 4'd0)
          state_nxt = bus.debug_en ? HALT : RUN;
      end
      RUN: begin
        if (bus.debug_en)
          state_nxt = HALT;
      end
      HALT: begin
        if (!bus.debug_en)
          state_nxt = RUN;
        else if (step_edge)
          state_nxt = STEP;
      end
      STEP: begin
        state_nxt = bus.debug_en ? HALT : RUN;
      end
    endcase
  end

  always_comb begin
    if_rst  = 1'b1;
    if_en   = 1'b0;
    id_rst  = 1'b1;
    id_en   = 1'b0;
    exe_rst = 1'b1;
    exe_en  = 1'b0;
    mem_rst = 1'b1;
    mem_en  = 1'b0;
    wb_rst  = 1'b1;
    wb_en   = 1'b0;
    halted  = 1'b0;
    if (!rst) begin
      unique case (state)
        INIT: begin
          halted = 1'b0;
        end
        HALT: begin
          // Frozen: no reset, no enable, contents held.
          if_rst  = 1'b0;
          id_rst  = 1'b0;
          exe_rst = 1'b0;
          mem_rst = 1'b0;
          wb_rst  = 1'b0;
          halted  = 1'b1;
        end
        RUN, STEP: begin
          if_rst  = 1'b0;
          wb_rst  = 1'b0;
          if_en   = 1'b1;
          wb_en   = 1'b1;
          unique case (1'b1)
            bus.is_branch_mem: begin
              // Squash the three younger instructions.
              id_rst  = 1'b1;
              exe_rst = 1'b1;
              mem_rst = 1'b1;
            end
            bus.reg_stall & ~bus.is_branch_mem: begin
              // Hold IF/ID, bubble into EXE.
              if_en   = 1'b0;
              id_rst  = 1'b0;
              exe_rst = 1'b1;
              mem_rst = 1'b0;
              mem_en  = 1'b1;
            end
            ~bus.reg_stall & ~bus.is_branch_mem: begin
              id_rst  = 1'b0;
              id_en   = 1'b1;
              exe_rst = 1'b0;
              exe_en  = 1'b1;
              mem_rst = 1'b0;
              mem_en  = 1'b1;
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (do_flush && flush_q != CNT_MAX)
        flush_q <= flush_q + 1'b1;
      if (do_stall && stall_q != CNT_MAX)
        stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.if_rst    = if_rst;
  assign bus.if_en     = if_en;
  assign bus.id_rst    = id_rst;
  assign bus.id_en     = id_en;
  assign bus.exe_rst   = exe_rst;
  assign bus.exe_en    = exe_en;
  assign bus.mem_rst   = mem_rst;
  assign bus.mem_en    = mem_en;
  assign bus.wb_rst    = wb_rst;
  assign bus.wb_en     = wb_en;
  assign bus.halted    = halted;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then random stimulus,
// all checked against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int RST_HOLD = 4;
  localparam int CNT_W    = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(
    .RST_HOLD (RST_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, got, exp);
    end
  endtask

  // Model: mode 0=init 1=run 2=halt 3=step
  int m_mode;
  int m_left;
  int m_stall;
  int m_flush;
  bit m_prev;

  // {if_rst,if_en,id_rst,id_en,exe_rst,exe_en,
  //  mem_rst,mem_en,wb_rst,wb_en,halted}
  function automatic logic [10:0] exp_ctl(bit r, bit st, bit br);
    if (r || m_mode == 0) return 11'b10101010100;
    if (m_mode == 2)      return 11'b00000000001;
    if (br)               return 11'b01101010010;
    if (st)               return 11'b00001001010;
    return 11'b01010101010;
  endfunction

  function automatic logic [10:0] got_ctl();
    return {bus.if_rst, bus.if_en, bus.id_rst, bus.id_en,
            bus.exe_rst, bus.exe_en, bus.mem_rst, bus.mem_en,
            bus.wb_rst, bus.wb_en, bus.halted};
  endfunction

  task automatic model_step(bit r, bit st, bit br, bit de, bit ds);
    bit act;
    bit edge_s;
    act = (m_mode == 1 || m_mode == 3);
    edge_s = ds && !m_prev;
    if (r) begin
      m_mode = 0; m_left = RST_HOLD;
      m_stall = 0; m_flush = 0; m_prev = 0;
      return;
    end
    if (act && br)      m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
    else if (act && st) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
    case (m_mode)
      0: begin
        m_left--;
        if (m_left == 0) m_mode = de ? 2 : 1;
      end
      1: if (de) m_mode = 2;
      2: if (!de) m_mode = 1; else if (edge_s) m_mode = 3;
      default: m_mode = de ? 2 : 1;
    endcase
    m_prev = ds;
  endtask

  // One cycle: drive, check mid-cycle, advance model across the edge.
  task automatic tick(bit r, bit st, bit br, bit de, bit ds, string tag);
    rst = r;
    bus.reg_stall = st;
    bus.is_branch_mem = br;
    bus.debug_en = de;
    bus.debug_step = ds;
    @(negedge clk);
    chk({tag, ".ctl"}, 32'(got_ctl()), 32'(exp_ctl(r, st, br)));
    chk({tag, ".stall"}, 32'(bus.stall_cnt), 32'(m_stall));
    chk({tag, ".flush"}, 32'(bus.flush_cnt), 32'(m_flush));
    model_step(r, st, br, de, ds);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.reg_stall = 0;
    bus.is_branch_mem = 0;
    bus.debug_en = 0;
    bus.debug_step = 0;
    m_mode = 0; m_left = RST_HOLD;
    m_stall = 0; m_flush = 0; m_prev = 0;
    @(posedge clk);
    #1;
    // reset and hold
    tick(1, 0, 0, 0, 0, "rst");
    tick(1, 0, 0, 0, 0, "rst");
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0, 0, "hold");
    // load-use stall, then stall+branch together
    tick(0, 1, 0, 0, 0, "stall");
    tick(0, 0, 0, 0, 0, "after_stall");
    tick(0, 1, 1, 0, 0, "stall_br");
    tick(0, 0, 1, 0, 0, "br");
    tick(0, 0, 0, 0, 0, "norm");
    // halt, step held 3 cycles, release
    tick(0, 0, 0, 1, 0, "run_to_halt");
    tick(0, 1, 0, 1, 0, "halt");
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 1, 1, "step");
    tick(0, 0, 0, 1, 0, "halt2");
    tick(0, 0, 0, 0, 1, "resume");
    tick(0, 0, 0, 0, 0, "run");
    // saturation
    for (int i = 0; i < 20; i++) tick(0, 1, 0, 0, 0, "sat");
    tick(0, 0, 0, 0, 0, "sat_end");
    // reset during STEP
    tick(0, 0, 0, 1, 0, "to_halt");
    tick(0, 0, 0, 1, 0, "halted");
    tick(0, 0, 0, 1, 1, "step_edge");
    tick(1, 0, 1, 1, 1, "rst_in_step");
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 1, 0, "reinit");
    // random
    for (int i = 0; i < 3000; i++) begin
      bit r, st, br, de, ds;
      r  = ($urandom_range(99) == 0);
      st = ($urandom_range(3) == 0);
      br = ($urandom_range(5) == 0);
      de = (i % 200) >= 120 ? ($urandom_range(19) != 0)
                            : ($urandom_range(19) == 0);
      ds = ($urandom_range(2) == 0);
      tick(r, st, br, de, ds, "rnd");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Stage-control sequencer for the 5-stage MIPS pipelined datapath.
- Drives every per-stage reset/enable pair: IF, ID, EXE, MEM and WB.
- Resolves load-use stalls and taken-branch flushes; the branch is resolved in MEM.
- Provides a debug halt/single-step mode and saturating stall/flush event counters for the debug bus.

Parameters:
RST_HOLD, 4, cycles all stage resets stay asserted after rst deasserts (1..15)
CNT_W, 16, width of stall/flush event counters

Ports:
clk  in  1  main clock, all logic on rising edge
rst  in  1  synchronous active-high reset
reg_stall  in  1  load-use hazard from ID; current-cycle value
is_branch_mem  in  1  taken branch in MEM; IF loads target this cycle
debug_en  in  1  1 = halt/step mode
debug_step  in  1  step request; rising edge (0->1 vs previous cycle) = one step
if_rst  out  1  IF stage reset
if_en  out  1  IF stage enable
id_rst  out  1  ID stage reset
id_en  out  1  ID stage enable
exe_rst  out  1  EXE stage reset (bubble insert)
exe_en  out  1  EXE stage enable
mem_rst  out  1  MEM stage reset
mem_en  out  1  MEM stage enable
wb_rst  out  1  WB stage reset
wb_en  out  1  WB stage enable
halted  out  1  1 while in HALT state
stall_cnt  out  CNT_W  cycles in which a load-use stall was applied, saturating
flush_cnt  out  CNT_W  cycles in which a branch flush was applied, saturating

Behaviour:
- States: INIT, RUN, HALT, STEP; 2-bit state register plus 4-bit hold counter; debug_step_d register for edge detect.
- rst=1: state<=INIT, hold counter<=RST_HOLD-1, counters<=0, debug_step_d<=0.
- Outputs while rst=1: all *_rst=1, all *_en=0, halted=0.
- INIT: all *_rst=1, all *_en=0; counter decrements.
  - At counter 0 the next state is HALT if debug_en=1, else RUN.
  - Net result: RST_HOLD cycles of INIT after rst falls.
- Stage control, combinational from state and inputs, applied in RUN and STEP ("active cycle"). Priority: branch > stall > normal.
  - Normal: all *_en=1, all *_rst=0.
  - Branch (is_branch_mem=1): if_en=1; id_rst=exe_rst=mem_rst=1 (flushes 3 younger instrs); wb_en=1; flush_cnt+1.
  - Stall (reg_stall=1, no branch): if_en=id_en=0; exe_rst=1 (bubble); mem_en=wb_en=1; stall_cnt+1.
  - Stall and branch in the same cycle: branch wins; only flush_cnt increments.
  - In any cycle where a *_rst is 1, the matching *_en is 0.
- RUN transitions: debug_en=1 -> HALT next cycle. The current cycle is still a full active cycle.
- HALT: all *_en=0, all *_rst=0 (pipeline frozen, contents kept); halted=1; no counter updates.
  - debug_en=0 -> RUN.
  - Else debug_step rising edge -> STEP.
  - Step edge and debug_en=0 in the same cycle: RUN wins.
- STEP: exactly one active cycle using the rules above, then HALT.
  - If debug_en=0 during STEP, next state is RUN.
  - A step edge arriving during STEP is ignored, not queued.
- Counters saturate at all-ones; no wrap.
- Reset mid-operation (any state) takes effect at the next edge; outputs follow the rst=1 rule immediately, since they are combinational on rst.
- Stage control outputs are combinational (no latency to reg_stall/is_branch_mem). State and counters update at the next edge.

Test Plan:
- Reset: rst=1 for 2 cycles then 0, debug_en=0, RST_HOLD=4 -> all *_rst=1 for 4 cycles after release; cycle 5 all *_en=1, *_rst=0; counters=0.
- Load-use stall: RUN, reg_stall=1 for 1 cycle -> that cycle if_en=0, id_en=0, exe_rst=1, mem_en=wb_en=1; stall_cnt 0->1; next cycle normal.
- Branch flush with simultaneous stall: is_branch_mem=1 and reg_stall=1 together -> if_en=1, id_rst=exe_rst=mem_rst=1, wb_en=1; flush_cnt=1, stall_cnt unchanged.
- Halt/step: debug_en=1 in RUN -> halted=1 next cycle, all en=0. Pulse debug_step 0->1 held 3 cycles -> exactly one active cycle, then halted=1. Drop debug_en -> RUN.
- Saturation: CNT_W=4, hold reg_stall=1 for 20 active cycles -> stall_cnt stops at 15.
- Mid-step reset: rst=1 during STEP -> same cycle all *_rst=1, halted=0; after release INIT for RST_HOLD cycles, then HALT if debug_en=1.
